// File: rtl/ifetch_buffer_pkg.sv
// ifetch_buffer_pkg: shared widths, PC constants, NOP encoding and bundle record {pc, data2, data1}
package ifetch_buffer_pkg;
    localparam int W = 32;
    localparam logic [W-1:0] PC_STEP = 32'd8;
    localparam logic [W-1:0] RESET_PC = 32'd0;
    localparam logic [W-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] data2;
        logic [W-1:0] data1;
    } bundle_t;
    localparam int BUNDLE_W = $bits(bundle_t);
endpackage

// File: rtl/ifetch_buffer_fifo.sv
// ifetch_buffer_fifo: DEPTH-entry bundle queue with occupancy count and synchronous flush
module ifetch_buffer_fifo
    import ifetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [BUNDLE_W-1:0]       wdata,
    output logic [BUNDLE_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    logic [BUNDLE_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupancy <= '0;
        end else begin
            assert (!(push && occupancy == OW'(DEPTH)));
            if (push) mem[wr_ptr] <= wdata;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            occupancy <= occupancy + OW'(push) - OW'(pop);
        end
    end
endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: bundle PC/request generation and queue to decode; IFB_BYPASS_EN enables empty-queue bypass
module ifetch_buffer
    import ifetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fetch_req,
    output logic [W-1:0]           fetch_pc,
    input  logic                   imem_valid,
    input  logic [W-1:0]           imem_data1,
    input  logic [W-1:0]           imem_data2,
    input  logic                   redirect_en,
    input  logic [W-1:0]           redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [W-1:0]           dec_data1,
    output logic [W-1:0]           dec_data2,
    output logic [W-1:0]           dec_pc,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int OW = $clog2(DEPTH) + 1;
    logic [W-1:0] tag_pc;
    logic inflight, drop, was_rst, push, fifo_push, pop;
    bundle_t resp, head, shown;
    assign fetch_req = !rst && !redirect_en && (occupancy + OW'(inflight) < OW'(DEPTH));
    assign push = imem_valid && inflight && !drop && !redirect_en;
    assign resp = '{pc: tag_pc, data2: imem_data2, data1: imem_data1};
`ifdef IFB_BYPASS_EN
    logic bypass;
    assign bypass = push && occupancy == '0;
    assign dec_valid = (occupancy != '0 || push) && !redirect_en;
    assign shown = bypass ? resp : head;
    assign fifo_push = push && !(bypass && dec_ready);
    assign pop = dec_valid && dec_ready && !bypass;
`else
    assign dec_valid = occupancy != '0 && !redirect_en;
    assign shown = head;
    assign fifo_push = push;
    assign pop = dec_valid && dec_ready;
`endif
    assign dec_pc = shown.pc;
    assign dec_data1 = dec_valid ? shown.data1 : NOP;
    assign dec_data2 = dec_valid ? shown.data2 : NOP;
    ifetch_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_en),
        .push(fifo_push),
        .pop(pop),
        .wdata(resp),
        .rdata(head),
        .occupancy(occupancy)
    );
    // drop covers a response still outstanding at redirect; a same-cycle response is already gated
    always_ff @(posedge clk) begin
        was_rst <= rst;
        tag_pc <= fetch_pc;
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            drop <= 1'b0;
        end else begin
            assert (was_rst || !(imem_valid && !inflight && !drop));
            fetch_pc <= redirect_en ? redirect_pc : fetch_req ? fetch_pc + PC_STEP : fetch_pc;
            inflight <= fetch_req;
            drop <= ((redirect_en && inflight) || drop) && !imem_valid;
        end
    end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed checks of fetch credit, ordering, redirect, PC wrap and reset recovery
module tb_ifetch_buffer;
    localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;
`ifdef IFB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fetch_req, dec_valid;
    logic [31:0] fetch_pc, dec_data1, dec_data2, dec_pc;
    logic imem_valid = 1'b0;
    logic [31:0] imem_data1 = '0;
    logic [31:0] imem_data2 = '0;
    logic redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic dec_ready = 1'b1;
    logic [2:0] occupancy;
    logic late = 1'b0;
    logic [31:0] nxt = '0;
    int checks = 0;
    int errors = 0;
    int pops = 0;

    ifetch_buffer dut (
        .clk(clk),
        .rst(rst),
        .fetch_req(fetch_req),
        .fetch_pc(fetch_pc),
        .imem_valid(imem_valid),
        .imem_data1(imem_data1),
        .imem_data2(imem_data2),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_data1(dec_data1),
        .dec_data2(dec_data2),
        .dec_pc(dec_pc),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic r;
        logic [31:0] p;
        @(negedge clk);
        r = fetch_req;
        p = fetch_pc;
        @(posedge clk);
        #1;
        imem_valid = r | late;
        imem_data1 = p ^ MAGIC;
        imem_data2 = p + 32'd4;
        late = 1'b0;
    endtask

    task automatic cycle();
        #1;
        if (dec_valid && dec_ready) begin
            chk("dec_pc", dec_pc, nxt);
            chk("dec_data1", dec_data1, nxt ^ MAGIC);
            chk("dec_data2", dec_data2, nxt + 32'd4);
            nxt += 32'd8;
            pops++;
        end
        tick();
    endtask

    task automatic stall_release();
        dec_ready = 1'b0;
        repeat (10) cycle();
        #1;
        chk("sat_occ", 32'(occupancy), 32'd4);
        chk("sat_req", 32'(fetch_req), 32'd0);
        chk("sat_valid", 32'(dec_valid), 32'd1);
        chk("sat_head", dec_pc, nxt);
        dec_ready = 1'b1;
        pops = 0;
        repeat (12) cycle();
        chk("release_pops", pops, 32'd12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        #1;
        chk("rst_pc", fetch_pc, 32'd0);
        chk("rst_req", 32'(fetch_req), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("c0_req", 32'(fetch_req), 32'd1);
        chk("c0_pc", fetch_pc, 32'd0);
        tick();
        nxt = 32'd0;
        pops = 0;
        #1;
        chk("startup_c1", 32'(dec_valid), 32'(LAT == 1));
        chk("c1_pc", fetch_pc, 32'd8);
        cycle();
        #1;
        chk("startup_c2", 32'(dec_valid), 32'd1);
        repeat (8) cycle();
        chk("stream_pops", pops, 32'(10 - LAT));
        chk("stream_req", 32'(fetch_req), 32'd1);

        stall_release();

        dec_ready = 1'b0;
        for (int i = 0; i < 10 && occupancy != 3'd3; i++) cycle();
        #1;
        chk("pre_redir_occ", 32'(occupancy), 32'd3);
        chk("pre_redir_req", 32'(fetch_req), 32'd0);
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("redir_valid", 32'(dec_valid), 32'd0);
        chk("redir_req", 32'(fetch_req), 32'd0);
        tick();
        redirect_en = 1'b0;
        #1;
        chk("post_redir_occ", 32'(occupancy), 32'd0);
        chk("post_redir_pc", fetch_pc, 32'h100);
        chk("post_redir_valid", 32'(dec_valid), 32'd0);
        chk("post_redir_req", 32'(fetch_req), 32'd1);
        dec_ready = 1'b1;
        nxt = 32'h100;
        pops = 0;
        repeat (5) cycle();
        chk("redir_pops", pops, 32'(5 - LAT));

        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("coinc_valid", 32'(dec_valid), 32'd0);
        tick();
        redirect_en = 1'b0;
        #1;
        chk("coinc_occ", 32'(occupancy), 32'd0);
        chk("coinc_pc", fetch_pc, 32'h200);
        nxt = 32'h200;
        pops = 0;
        repeat (5) cycle();
        chk("coinc_pops", pops, 32'(5 - LAT));

        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_en = 1'b0;
        #1;
        chk("wrap_start", fetch_pc, 32'hFFFF_FFF8);
        chk("wrap_req", 32'(fetch_req), 32'd1);
        tick();
        #1;
        chk("wrap_pc", fetch_pc, 32'd0);
        nxt = 32'hFFFF_FFF8;
        pops = 0;
        repeat (5) cycle();
        chk("wrap_pops", pops, 32'(6 - LAT));

        rst = 1'b1;
        late = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_pc", fetch_pc, 32'd0);
        chk("mid_rst_valid", 32'(dec_valid), 32'd0);
        chk("mid_rst_req", 32'(fetch_req), 32'd1);
        tick();
        #1;
        chk("late_occ", 32'(occupancy), 32'd0);
        chk("late_valid", 32'(dec_valid), 32'(LAT == 1));
        nxt = 32'd0;
        pops = 0;
        repeat (5) cycle();
        chk("restart_pops", pops, 32'(6 - LAT));

        stall_release();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
